// File: rtl/rx_cfg_pkg.sv
// Shared types and widths for the receiver configuration path.
package rx_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_ACK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int COEF_WORD_W = 64;
    localparam int LOCATION_W  = 8;

endpackage

// File: rtl/pulse_resp_loader_if.sv
// On-chip memory read port plus DFE coefficient load port, as seen by the loader.
interface pulse_resp_loader_if
    import rx_cfg_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8
) ();

    logic                      mem_rd_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [COEF_WORD_W-1:0]    mem_rdata;
    logic                      load_mem;
    logic [LOCATION_W-1:0]     location;
    logic [COEF_WORD_W-1:0]    mem_data;
    logic                      done_wait;

    // Loader side: drives the read strobe and the DFE write port.
    modport master (
        output mem_rd_en, mem_addr, load_mem, location, mem_data,
        input  mem_rdata, done_wait
    );

    // Memory / DFE side.
    modport slave (
        input  mem_rd_en, mem_addr, load_mem, location, mem_data,
        output mem_rdata, done_wait
    );

endinterface

// File: rtl/read_tag_pipe.sv
// Depth-L shift register carrying {valid, index} alongside an OCM read so the
// returning data can be matched to the request that produced it.
module read_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             busy_o
);

    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift tags one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/pulse_resp_loader.sv
// Reads the pulse-response coefficients from OCM, writes them into the DFE,
// then waits for the DFE acknowledgement and reports loaded or error.
module pulse_resp_loader
    import rx_cfg_pkg::*;
#(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int MEM_ADDR_WIDTH        = 8,
    parameter int MEM_READ_LATENCY      = 2,
    parameter int BASE_ADDR             = 0,
    parameter int ACK_TIMEOUT           = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    pulse_resp_loader_if.master  bus,
    output logic                 busy,
    output logic                 loaded,
    output logic                 error
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    if (PULSE_RESPONSE_LENGTH < 1 || PULSE_RESPONSE_LENGTH > 256) begin : g_bad_len
        $error("PULSE_RESPONSE_LENGTH must be 1..256");
    end
    if (MEM_READ_LATENCY < 1) begin : g_bad_lat
        $error("MEM_READ_LATENCY must be >= 1");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_tmo
        $error("ACK_TIMEOUT must be >= 1");
    end

    logic [1:0]                rst_sync_q;
    logic                      rst_n_s;
    loader_state_t             state_q;
    logic                      rd_en_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [LOCATION_W-1:0]     idx_q;
    logic [8:0]                issue_cnt_q;
    logic [ACK_W-1:0]          ack_cnt_q;
    logic                      load_q;
    logic [LOCATION_W-1:0]     loc_q;
    logic [COEF_WORD_W-1:0]    data_q;
    logic                      busy_q;
    logic                      loaded_q;
    logic                      error_q;
    logic                      tag_valid;
    logic [LOCATION_W-1:0]     tag_idx;
    logic                      pipe_busy;

    // Reset synchronizer: immediate assertion, release two edges after rstn rises.
    // NOTE: asserting asynchronously but releasing on a clock edge keeps every
    // downstream flop from leaving reset in different cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    read_tag_pipe #(
        .DEPTH (MEM_READ_LATENCY),
        .IDX_W (LOCATION_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n_s),
        .valid_i (rd_en_q),
        .idx_i   (idx_q),
        .valid_o (tag_valid),
        .idx_o   (tag_idx),
        .busy_o  (pipe_busy)
    );

    // Sequencer with registered outputs; the load port follows the tag pipe.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            idx_q       <= '0;
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
            load_q      <= 1'b0;
            loc_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // Returned word is captured as it meets its tag; zero when idle.
            load_q <= tag_valid;
            loc_q  <= tag_valid ? tag_idx : '0;
            data_q <= tag_valid ? bus.mem_rdata : '0;

            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        loaded_q    <= 1'b0;
                        error_q     <= 1'b0;
                        rd_en_q     <= 1'b1;
                        addr_q      <= MEM_ADDR_WIDTH'(BASE_ADDR);
                        idx_q       <= '0;
                        issue_cnt_q <= 9'd1;
                    end
                end
                ISSUE: begin
                    if (issue_cnt_q == 9'(PULSE_RESPONSE_LENGTH)) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_en_q     <= 1'b1;
                        addr_q      <= MEM_ADDR_WIDTH'(BASE_ADDR) + MEM_ADDR_WIDTH'(issue_cnt_q);
                        idx_q       <= issue_cnt_q[LOCATION_W-1:0];
                        issue_cnt_q <= issue_cnt_q + 9'd1;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy && !load_q) begin
                        state_q   <= WAIT_ACK;
                        ack_cnt_q <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (bus.done_wait) begin
                        state_q  <= DONE;
                        loaded_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
                    end
                end
                // NOTE: default arm returns to IDLE so an illegal encoding cannot lock the FSM.
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_addr  = addr_q;
    assign bus.load_mem  = load_q;
    assign bus.location  = loc_q;
    assign bus.mem_data  = data_q;
    assign busy          = busy_q;
    assign loaded        = loaded_q;
    assign error         = error_q;

endmodule

// File: tb/tb_pulse_resp_loader.sv
// Bench for pulse_resp_loader: dut_a uses defaults, dut_b uses latency 4,
// base address 0xFE and a 10-cycle ack timeout. Memory word at address a is 0xA0+a.
module tb_pulse_resp_loader;

    typedef struct { int cyc; logic [7:0] addr; } rd_t;
    typedef struct { int cyc; logic [7:0] loc; logic [63:0] data; } ld_t;
    typedef struct { logic [7:0] loc; logic [63:0] data; } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic rstn_a, start_a, busy_a, loaded_a, error_a, dw_a;
    logic rstn_b, start_b, busy_b, loaded_b, error_b, dw_b;

    logic [63:0] mp_a [2];
    logic [63:0] mp_b [4];

    rd_t  rd_a[$], rd_b[$];
    ld_t  ld_a[$], ld_b[$];
    exp_t exp_a[$], exp_b[$];
    int   idle_bad_a = 0;
    int   idle_bad_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_resp_loader_if #(.MEM_ADDR_WIDTH(8)) if_a ();
    pulse_resp_loader_if #(.MEM_ADDR_WIDTH(8)) if_b ();

    pulse_resp_loader dut_a (
        .clk    (clk),
        .rstn   (rstn_a),
        .start  (start_a),
        .bus    (if_a),
        .busy   (busy_a),
        .loaded (loaded_a),
        .error  (error_a)
    );

    pulse_resp_loader #(
        .MEM_READ_LATENCY (4),
        .BASE_ADDR        (8'hFE),
        .ACK_TIMEOUT      (10)
    ) dut_b (
        .clk    (clk),
        .rstn   (rstn_b),
        .start  (start_b),
        .bus    (if_b),
        .busy   (busy_b),
        .loaded (loaded_b),
        .error  (error_b)
    );

    // Memory models: data appears exactly the read latency after the strobe.
    always @(posedge clk) begin
        mp_a[0] <= if_a.mem_rd_en ? 64'hA0 + 64'(if_a.mem_addr) : 64'hDEAD;
        mp_a[1] <= mp_a[0];
        mp_b[0] <= if_b.mem_rd_en ? 64'hA0 + 64'(if_b.mem_addr) : 64'hDEAD;
        for (int i = 1; i < 4; i++) mp_b[i] <= mp_b[i-1];
    end
    assign if_a.mem_rdata = mp_a[1];
    assign if_b.mem_rdata = mp_b[3];
    assign if_a.done_wait = dw_a;
    assign if_b.done_wait = dw_b;

    // Output monitors: log reads and loads with their cycle numbers.
    always @(negedge clk) begin
        rd_t r;
        ld_t l;
        if (if_a.mem_rd_en) begin
            r.cyc = cyc; r.addr = if_a.mem_addr; rd_a.push_back(r);
        end
        if (if_a.load_mem) begin
            l.cyc = cyc; l.loc = if_a.location; l.data = if_a.mem_data; ld_a.push_back(l);
        end else if (if_a.location != 8'd0 || if_a.mem_data != 64'd0) begin
            idle_bad_a++;
        end
        if (if_b.mem_rd_en) begin
            r.cyc = cyc; r.addr = if_b.mem_addr; rd_b.push_back(r);
        end
        if (if_b.load_mem) begin
            l.cyc = cyc; l.loc = if_b.location; l.data = if_b.mem_data; ld_b.push_back(l);
        end else if (if_b.location != 8'd0 || if_b.mem_data != 64'd0) begin
            idle_bad_b++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_exp(input bit sel, input logic [7:0] base);
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.loc  = 8'(k);
            e.data = 64'hA0 + 64'(8'(base + 8'(k)));
            if (sel) exp_b.push_back(e);
            else     exp_a.push_back(e);
        end
    endtask

    // Compare one 5-word sequence whose first strobe is at cycle t0.
    task automatic check_seq(input bit sel, input int rd0, input int ld0, input int t0,
                             input int lat, input logic [7:0] base);
        rd_t  r;
        ld_t  l;
        exp_t e;
        check("rd_count", 64'(sel ? rd_b.size() - rd0 : rd_a.size() - rd0), 64'd5);
        check("ld_count", 64'(sel ? ld_b.size() - ld0 : ld_a.size() - ld0), 64'd5);
        for (int k = 0; k < 5; k++) begin
            r = '{-1, 8'h00};
            l = '{-1, 8'h00, 64'h0};
            e = '{8'hEE, 64'hEEEE};
            if (sel) begin
                if (rd0 + k < rd_b.size()) r = rd_b[rd0 + k];
                if (ld0 + k < ld_b.size()) l = ld_b[ld0 + k];
                if (exp_b.size() > 0)      e = exp_b.pop_front();
            end else begin
                if (rd0 + k < rd_a.size()) r = rd_a[rd0 + k];
                if (ld0 + k < ld_a.size()) l = ld_a[ld0 + k];
                if (exp_a.size() > 0)      e = exp_a.pop_front();
            end
            check("rd_cycle", 64'(r.cyc), 64'(t0 + k));
            check("rd_addr", 64'(r.addr), 64'(8'(base + 8'(k))));
            check("ld_cycle", 64'(l.cyc), 64'(t0 + k + lat + 1));
            check("ld_location", 64'(l.loc), 64'(e.loc));
            check("ld_data", l.data, e.data);
        end
    endtask

    initial begin
        int rd0;
        int ld0;
        rstn_a = 1'b0; rstn_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        dw_a = 1'b0; dw_b = 1'b0;

        // Reset state
        wait_to(1);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_loaded_a", 64'(loaded_a), 64'd0);
        check("rst_error_a", 64'(error_a), 64'd0);
        check("rst_rd_en_a", 64'(if_a.mem_rd_en), 64'd0);
        check("rst_load_a", 64'(if_a.load_mem), 64'd0);
        check("rst_busy_b", 64'(busy_b), 64'd0);
        check("rst_error_b", 64'(error_b), 64'd0);
        wait_to(2);
        rstn_a = 1'b1; rstn_b = 1'b1;

        // Test 1: default load, ack raised while in WAIT_ACK
        wait_to(10);
        push_exp(1'b0, 8'h00);
        start_a = 1'b1;
        wait_to(11);
        start_a = 1'b0;
        check("t1_busy_after_start", 64'(busy_a), 64'd1);
        wait_to(21);
        check("t1_loaded_before_ack", 64'(loaded_a), 64'd0);
        check("t1_busy_before_ack", 64'(busy_a), 64'd1);
        wait_to(22);
        dw_a = 1'b1;
        wait_to(23);
        dw_a = 1'b0;
        check("t1_loaded", 64'(loaded_a), 64'd1);
        check("t1_busy_done", 64'(busy_a), 64'd0);
        check("t1_error", 64'(error_a), 64'd0);
        check_seq(1'b0, 0, 0, 11, 2, 8'h00);

        // Test 4: restart from DONE, extra starts in ISSUE and WAIT_ACK ignored
        wait_to(30);
        rd0 = rd_a.size(); ld0 = ld_a.size();
        push_exp(1'b0, 8'h00);
        start_a = 1'b1;
        wait_to(31);
        start_a = 1'b0;
        check("t4_loaded_cleared", 64'(loaded_a), 64'd0);
        wait_to(32);
        start_a = 1'b1;
        wait_to(33);
        start_a = 1'b0;
        wait_to(41);
        start_a = 1'b1;
        wait_to(42);
        start_a = 1'b0;
        check("t4_busy_wait_ack", 64'(busy_a), 64'd1);
        check("t4_loaded_wait_ack", 64'(loaded_a), 64'd0);
        wait_to(43);
        dw_a = 1'b1;
        wait_to(44);
        dw_a = 1'b0;
        check("t4_loaded", 64'(loaded_a), 64'd1);
        check_seq(1'b0, rd0, ld0, 31, 2, 8'h00);

        // Test 6: done_wait already high before WAIT_ACK
        wait_to(49);
        dw_a = 1'b1;
        wait_to(50);
        rd0 = rd_a.size(); ld0 = ld_a.size();
        push_exp(1'b0, 8'h00);
        start_a = 1'b1;
        wait_to(51);
        start_a = 1'b0;
        wait_to(60);
        check("t6_loaded_in_wait_ack", 64'(loaded_a), 64'd0);
        wait_to(61);
        check("t6_loaded", 64'(loaded_a), 64'd1);
        check("t6_busy", 64'(busy_a), 64'd0);
        dw_a = 1'b0;
        check_seq(1'b0, rd0, ld0, 51, 2, 8'h00);

        // Test 5: reset after the second load, then a clean run
        wait_to(70);
        ld0 = ld_a.size();
        start_a = 1'b1;
        wait_to(71);
        start_a = 1'b0;
        wait_to(75);
        #2 rstn_a = 1'b0;
        #1;
        check("t5_busy_async", 64'(busy_a), 64'd0);
        check("t5_loaded_async", 64'(loaded_a), 64'd0);
        check("t5_error_async", 64'(error_a), 64'd0);
        check("t5_rd_en_async", 64'(if_a.mem_rd_en), 64'd0);
        check("t5_load_async", 64'(if_a.load_mem), 64'd0);
        check("t5_location_async", 64'(if_a.location), 64'd0);
        check("t5_data_async", if_a.mem_data, 64'd0);
        wait_to(80);
        check("t5_loads_before_reset", 64'(ld_a.size() - ld0), 64'd2);
        rstn_a = 1'b1;
        wait_to(84);
        check("t5_no_load_after_reset", 64'(ld_a.size() - ld0), 64'd2);
        wait_to(85);
        rd0 = rd_a.size(); ld0 = ld_a.size();
        push_exp(1'b0, 8'h00);
        start_a = 1'b1;
        wait_to(86);
        start_a = 1'b0;
        wait_to(94);
        dw_a = 1'b1;
        wait_to(95);
        check("t5_loaded_in_wait_ack", 64'(loaded_a), 64'd0);
        wait_to(96);
        dw_a = 1'b0;
        check("t5_loaded", 64'(loaded_a), 64'd1);
        check_seq(1'b0, rd0, ld0, 86, 2, 8'h00);

        // Tests 2 and 3: latency 4, base 0xFE wrap, ack timeout of 10
        wait_to(110);
        rd0 = rd_b.size(); ld0 = ld_b.size();
        push_exp(1'b1, 8'hFE);
        start_b = 1'b1;
        wait_to(111);
        start_b = 1'b0;
        wait_to(131);
        check("t3_error_before_timeout", 64'(error_b), 64'd0);
        check("t3_busy_before_timeout", 64'(busy_b), 64'd1);
        wait_to(132);
        check("t3_error", 64'(error_b), 64'd1);
        check("t3_loaded", 64'(loaded_b), 64'd0);
        check("t3_busy", 64'(busy_b), 64'd0);
        check_seq(1'b1, rd0, ld0, 111, 4, 8'hFE);
        wait_to(139);
        check("t3_error_sticky", 64'(error_b), 64'd1);
        wait_to(140);
        rd0 = rd_b.size(); ld0 = ld_b.size();
        push_exp(1'b1, 8'hFE);
        start_b = 1'b1;
        wait_to(141);
        start_b = 1'b0;
        check("t3_error_cleared", 64'(error_b), 64'd0);
        check("t3_busy_restart", 64'(busy_b), 64'd1);
        wait_to(162);
        check("t3_error_again", 64'(error_b), 64'd1);
        check_seq(1'b1, rd0, ld0, 141, 4, 8'hFE);

        check("idle_port_zero_a", 64'(idle_bad_a), 64'd0);
        check("idle_port_zero_b", 64'(idle_bad_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
